// File: rtl/dual_port_mem_responder_if.sv
// CPU <-> memory responder bus for the instruction port (1) and the data port (2).
// The bidirectional data2 line is carried as a plain inout port on the responder.
interface dual_port_mem_responder_if #(
   parameter int WORD_SIZE = 16
);
   logic                 readM1;
   logic [WORD_SIZE-1:0] address1;
   logic [WORD_SIZE-1:0] data1;
   logic                 ready1;
   logic                 readM2;
   logic                 writeM2;
   logic [WORD_SIZE-1:0] address2;
   logic                 ready2;

   // Handshake: the CPU raises a request with its address (and data2 for writes)
   // and holds it until the matching ready pulses for one cycle; the access is
   // accepted on the first posedge the port is idle and the request is high.
   modport master (
      output readM1, address1, readM2, writeM2, address2,
      input  data1, ready1, ready2
   );

   modport slave (
      input  readM1, address1, readM2, writeM2, address2,
      output data1, ready1, ready2
   );
endinterface

// File: rtl/dual_port_mem_responder.sv
// Fixed-latency memory responder: read-only instruction port and read/write data port,
// each with its own IDLE/WAIT/RESP sequencer, sharing one word array.
module dual_port_mem_responder #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_BITS = 10,
   parameter int LATENCY   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   dual_port_mem_responder_if.slave   bus,
   inout  wire  [WORD_SIZE-1:0]       data2,
   output logic [1:0]                 dbg_state1,
   output logic [1:0]                 dbg_state2,
   output logic                       dbg_drive2
);
   localparam int DEPTH = 2 ** ADDR_BITS;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t                 st1, st2;
   logic [3:0]             cnt1, cnt2;
   logic [ADDR_BITS-1:0]   addr1, addr2;
   logic                   wr2;
   logic [WORD_SIZE-1:0]   wdata2, rdata2;
   logic                   drive2;
   logic [WORD_SIZE-1:0]   mem [DEPTH];

   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.address1[WORD_SIZE-1:ADDR_BITS],
                               bus.address2[WORD_SIZE-1:ADDR_BITS]};

   // RESP is the cycle in which read data is captured; ready pulses the cycle
   // after, as the sequencer is already back in IDLE and may accept again.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st1        <= IDLE;
         cnt1       <= '0;
         addr1      <= '0;
         bus.ready1 <= 1'b0;
         bus.data1  <= '0;
      end else begin
         bus.ready1 <= 1'b0;
         case (st1)
            IDLE: if (bus.readM1) begin
               addr1 <= bus.address1[ADDR_BITS-1:0];
               if (LATENCY == 1) begin
                  st1       <= RESP;
                  bus.data1 <= mem[bus.address1[ADDR_BITS-1:0]];
               end else begin
                  st1  <= WAIT;
                  cnt1 <= 4'(LATENCY - 1);
               end
            end
            WAIT: if (cnt1 == 4'd1) begin
               st1       <= RESP;
               bus.data1 <= mem[addr1];
            end else begin
               cnt1 <= cnt1 - 4'd1;
            end
            RESP: begin
               st1        <= IDLE;
               bus.ready1 <= 1'b1;
            end
            default: st1 <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st2        <= IDLE;
         cnt2       <= '0;
         addr2      <= '0;
         wr2        <= 1'b0;
         wdata2     <= '0;
         rdata2     <= '0;
         drive2     <= 1'b0;
         bus.ready2 <= 1'b0;
      end else begin
         bus.ready2 <= 1'b0;
         drive2     <= 1'b0;
         case (st2)
            IDLE: if (bus.readM2 || bus.writeM2) begin
               addr2  <= bus.address2[ADDR_BITS-1:0];
               wr2    <= bus.writeM2;
               wdata2 <= data2;
               if (LATENCY == 1) begin
                  st2 <= RESP;
                  if (!bus.writeM2) rdata2 <= mem[bus.address2[ADDR_BITS-1:0]];
               end else begin
                  st2  <= WAIT;
                  cnt2 <= 4'(LATENCY - 1);
               end
            end
            WAIT: if (cnt2 == 4'd1) begin
               st2 <= RESP;
               if (!wr2) rdata2 <= mem[addr2];
            end else begin
               cnt2 <= cnt2 - 4'd1;
            end
            RESP: begin
               st2        <= IDLE;
               bus.ready2 <= 1'b1;
               drive2     <= !wr2;
            end
            default: st2 <= IDLE;
         endcase
      end
   end

   // Commit on the edge leaving RESP, so a port-1 read captured earlier sees old data.
   always_ff @(posedge clk) begin
      if (!reset && st2 == RESP && wr2) mem[addr2] <= wdata2;
   end

   assign data2      = drive2 ? rdata2 : 'z;
   assign dbg_state1 = st1;
   assign dbg_state2 = st2;
   assign dbg_drive2 = drive2;
endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Scoreboard bench for dual_port_mem_responder: per-port expected queues, latency
// and pulse-spacing checks, collision, aliasing and mid-transaction reset.
module tb_dual_port_mem_responder;
   localparam int W   = 16;
   localparam int AB  = 10;
   localparam int LAT = 4;

   // clock / reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dual_port_mem_responder_if #(.WORD_SIZE(W)) bus ();
   wire  [W-1:0] data2;
   logic         tb_drv;
   logic [W-1:0] tb_wdata;
   logic [1:0]   dbg_state1, dbg_state2;
   logic         dbg_drive2;

   assign data2 = tb_drv ? tb_wdata : 'z;

   dual_port_mem_responder #(.WORD_SIZE(W), .ADDR_BITS(AB), .LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .data2      (data2),
      .dbg_state1 (dbg_state1),
      .dbg_state2 (dbg_state2),
      .dbg_drive2 (dbg_drive2)
   );

   int           vectors = 0;
   int           errors  = 0;
   logic [W-1:0] model_mem [1 << AB];
   logic [W-1:0] exp1_q[$];
   logic [W:0]   exp2_q[$];   // bit W set = read with data, clear = write
   logic [W-1:0] e1;
   logic [W:0]   e2;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // scoreboard
   always @(negedge clk) begin
      if (bus.ready1) begin
         if (exp1_q.size() == 0) check("p1_spurious_ready", 32'(bus.ready1), 32'd0);
         else begin
            e1 = exp1_q.pop_front();
            check("data1", 32'(bus.data1), 32'(e1));
         end
      end
      if (bus.ready2) begin
         if (exp2_q.size() == 0) check("p2_spurious_ready", 32'(bus.ready2), 32'd0);
         else begin
            e2 = exp2_q.pop_front();
            if (e2[W]) begin
               check("data2", 32'(data2), 32'(e2[W-1:0]));
               check("drive2_read", 32'(dbg_drive2), 32'd1);
            end else begin
               check("drive2_write", 32'(dbg_drive2), 32'd0);
            end
         end
      end else begin
         check("data2_z", 32'(dbg_drive2), 32'd0);
      end
   end

   // drivers
   task automatic p1_drive(input logic [W-1:0] addr);
      int n;
      @(negedge clk);
      bus.readM1   = 1'b1;
      bus.address1 = addr;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.ready1 && n < 40);
      bus.readM1 = 1'b0;
      check("lat1", 32'(n), 32'(LAT + 1));
   endtask

   task automatic p2_drive(input logic [W-1:0] addr, input logic wr, input logic [W-1:0] wd);
      int n;
      @(negedge clk);
      bus.address2 = addr;
      if (wr) begin
         bus.writeM2 = 1'b1;
         tb_drv      = 1'b1;
         tb_wdata    = wd;
      end else begin
         bus.readM2 = 1'b1;
      end
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.ready2 && n < 40);
      bus.writeM2 = 1'b0;
      bus.readM2  = 1'b0;
      tb_drv      = 1'b0;
      check("lat2", 32'(n), 32'(LAT + 1));
   endtask

   task automatic read1(input logic [W-1:0] addr);
      exp1_q.push_back(model_mem[addr[AB-1:0]]);
      p1_drive(addr);
   endtask

   task automatic read2(input logic [W-1:0] addr);
      exp2_q.push_back({1'b1, model_mem[addr[AB-1:0]]});
      p2_drive(addr, 1'b0, '0);
   endtask

   task automatic write2(input logic [W-1:0] addr, input logic [W-1:0] val);
      model_mem[addr[AB-1:0]] = val;
      exp2_q.push_back({1'b0, val});
      p2_drive(addr, 1'b1, val);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int           t[3];
      int           pulses;
      logic [W-1:0] a, d;

      reset        = 1'b1;
      bus.readM1   = 1'b0;
      bus.address1 = '0;
      bus.readM2   = 1'b0;
      bus.writeM2  = 1'b0;
      bus.address2 = '0;
      tb_drv       = 1'b0;
      tb_wdata     = '0;
      repeat (3) @(negedge clk);
      check("rst_ready1", 32'(bus.ready1), 32'd0);
      check("rst_ready2", 32'(bus.ready2), 32'd0);
      check("rst_data1",  32'(bus.data1),  32'd0);
      check("rst_drive2", 32'(dbg_drive2), 32'd0);
      check("rst_state1", 32'(dbg_state1), 32'd0);
      check("rst_state2", 32'(dbg_state2), 32'd0);
      reset = 1'b0;

      // basic port-1 read latency
      write2(16'h0000, 16'h6000);
      read1(16'h0000);

      // port-2 write then read
      write2(16'h0010, 16'h1234);
      read2(16'h0010);

      // same-edge port-1 read and port-2 write: read returns old data
      exp1_q.push_back(model_mem[10'h010]);
      model_mem[10'h010] = 16'hBEEF;
      exp2_q.push_back({1'b0, 16'hBEEF});
      fork
         p1_drive(16'h0010);
         p2_drive(16'h0010, 1'b1, 16'hBEEF);
      join
      read1(16'h0010);

      // held request: three back-to-back accesses
      write2(16'h0005, 16'h00A5);
      repeat (3) exp1_q.push_back(model_mem[10'h005]);
      @(negedge clk);
      bus.readM1   = 1'b1;
      bus.address1 = 16'h0005;
      pulses = 0;
      for (int n = 1; n <= 40 && pulses < 3; n++) begin
         @(negedge clk);
         if (bus.ready1) begin
            t[pulses] = n;
            pulses++;
         end
      end
      bus.readM1 = 1'b0;
      check("b2b_pulses", 32'(pulses), 32'd3);
      if (pulses == 3) begin
         check("b2b_first", 32'(t[0]), 32'(LAT + 1));
         check("b2b_gap1", 32'(t[1] - t[0]), 32'(LAT + 1));
         check("b2b_gap2", 32'(t[2] - t[1]), 32'(LAT + 1));
      end

      // reset during WAIT of a write discards it
      write2(16'h0020, 16'h1111);
      @(negedge clk);
      bus.writeM2  = 1'b1;
      bus.address2 = 16'h0020;
      tb_drv       = 1'b1;
      tb_wdata     = 16'hAAAA;
      repeat (2) @(negedge clk);
      check("mid_state2_wait", 32'(dbg_state2), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_ready2", 32'(bus.ready2), 32'd0);
      check("mid_rst_drive2", 32'(dbg_drive2), 32'd0);
      check("mid_rst_state2", 32'(dbg_state2), 32'd0);
      check("mid_rst_data1",  32'(bus.data1),  32'd0);
      bus.writeM2 = 1'b0;
      tb_drv      = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      read2(16'h0020);
      read1(16'h0020);

      // upper address bits alias
      write2(16'h0410, 16'h5555);
      read2(16'h0010);
      read1(16'h0810);

      // random writes, then concurrent reads on both ports
      for (int i = 0; i < 6; i++) begin
         a = 16'($urandom_range(0, 65535));
         d = 16'($urandom_range(0, 65535));
         write2(a, d);
         fork
            read1(a);
            read2(a ^ 16'h0400);
         join
      end

      repeat (3) @(negedge clk);
      check("sb1_left", 32'(exp1_q.size()), 32'd0);
      check("sb2_left", 32'(exp2_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
